delay_slot_ctrl: RTL and testbench
==================================

# delay_slot_ctrl

Parametrised delay-slot / bubble controller between instruction fetch and decode. Classifies each instruction as it enters decode (branch class, memory class, or other) and inserts a per-class, configurable number of NOP bubbles after it. In squash mode the bubble replaces the following instruction. In stall mode it holds fetch so the following instruction is preserved. Adds a pipeline-advance enable, a flush input and a saturating bubble counter for performance monitoring.

## Interface
- WIDTH, 32: instruction width.
- BR_SLOTS, 1: bubbles after a branch-class instruction (0..15; 0 disables).
- MEM_SLOTS, 1: bubbles after a memory-class instruction (0..15; 0 disables).
- BR_STALL, 0: 1 = branch bubbles stall fetch; 0 = branch bubbles squash the next instruction.
- MEM_STALL, 1: the same stall/squash selection, for memory-class bubbles.
- NOP, 32'h910003FF: word driven during bubbles (ADDI XZR, XZR, #0).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high.
- en  in  1  pipeline advance. When 0, all state is frozen.
- flush  in  1  kills outstanding bubbles (redirect/exception).
- instr_in  in  WIDTH  instruction arriving from fetch.
- instr_out  out  WIDTH  instruction delivered to decode.
- bubble  out  1  instr_out is an inserted NOP this cycle.
- stall_fetch  out  1  fetch must hold PC and re-present instr_in next cycle.
- slot_cnt  out  4  bubbles remaining, including the current one.
- bubble_total  out  16  count of bubbles issued; saturates at 16'hFFFF.

## Operation
- Classification applies to instr_in only when bubble=0:
  - Branch class: instr_in[28:26] == 3'b101.
  - Memory class: instr_in[31:23] == 9'b111110000 and instr_in[21] == 0 (LDUR/STUR). The two classes are disjoint.
  - Other: no bubbles.
- Registered state:
  - slot_cnt[3:0].
  - mode bit: 1 = stall, 0 = squash, latched from the class that triggered.
  - bubble_total.
- FSM states:
  - IDLE (slot_cnt == 0):
    - en=1 and branch-class instr_in with BR_SLOTS>0 -> BUSY with slot_cnt=BR_SLOTS, mode=BR_STALL.
    - en=1 and memory-class instr_in with MEM_SLOTS>0 -> BUSY with slot_cnt=MEM_SLOTS, mode=MEM_STALL.
    - Otherwise stay in IDLE.
  - BUSY (slot_cnt > 0): on each en=1 edge, slot_cnt decrements and bubble_total increments (saturating). The transition to 1 -> 0 returns to IDLE.
- Combinational outputs:
  - bubble = (slot_cnt != 0).
  - instr_out = bubble ? NOP : instr_in.
  - stall_fetch = bubble & mode.
- During BUSY, instr_in is not classified. In squash mode it is discarded. In stall mode fetch re-presents it and it is classified normally on the first IDLE cycle.
- flush=1 with en=1: slot_cnt <= 0 and no new classification that cycle. flush has priority over both decrement and load. bubble_total is not incremented on a flushed edge.
- flush=1 with en=0: ignored.
- reset has priority over everything and over en. Reset values: slot_cnt=0, mode=0, bubble_total=0. The resulting outputs are bubble=0, stall_fetch=0, instr_out=instr_in.
- Reset mid-BUSY abandons the remaining bubbles immediately.

## Timing
- A qualifying instruction is passed through unchanged in cycle k (accepted at the edge ending cycle k). Bubbles occupy the next N en-cycles, k+1..k+N, where N = BR_SLOTS or MEM_SLOTS.
- Zero-latency mux: instr_out, bubble and stall_fetch depend combinationally on registered state and instr_in only. There is no combinational path from en or flush to the outputs.
- With en=0 inside BUSY, the same bubble is re-driven; slot_cnt and bubble_total hold.
- Back-to-back: a qualifying instruction presented in the first IDLE cycle after BUSY triggers a new BUSY with no gap cycle.
- bubble_total updates one edge after each issued bubble.

## Test plan
- Reset then ADD (32'h8B020020) with en=1 -> instr_out=32'h8B020020, bubble=0, stall_fetch=0, slot_cnt=0, bubble_total=0.
- Defaults; B (32'h14000004), then ADD -> cycle 1 outputs the B word; cycle 2 has instr_out=32'h910003FF, bubble=1, stall_fetch=0 (ADD squashed); cycle 3 is IDLE; bubble_total=1.
- Defaults; LDUR (32'hF8400020), then ADD held by fetch -> one bubble with stall_fetch=1; ADD is delivered on the next cycle; bubble_total=1.
- MEM_SLOTS=3; LDUR, with en=0 during the second bubble -> slot_cnt sequence 3,2,2,1,0; exactly 3 NOPs reach decode; bubble_total=3.
- BR_SLOTS=4; branch, flush=1 with en=1 in the 2nd bubble cycle -> bubble=0 on the next cycle; bubble_total=1.
- bubble_total preloaded near saturation by a long run (BR_SLOTS=15, repeated branches) -> stops at 16'hFFFF. Reset asserted mid-BUSY -> outputs go to their reset values on the next cycle.

Source files
------------

// File: rtl/delay_slot_ctrl.sv
// rtl/delay_slot_ctrl.sv - delay-slot / bubble controller between fetch and decode
//
// Purpose:
//   Classifies each instruction entering decode as branch class, memory class
//   or other, and inserts a per-class number of NOP bubbles after a qualifying
//   instruction. Each class selects either squash mode, where the bubble
//   replaces the following instruction, or stall mode, where fetch holds so the
//   following instruction is preserved. A saturating counter records the
//   number of bubbles issued.
//
// Ports:
//   clk          in   1      rising-edge clock
//   reset        in   1      synchronous, active-high; overrides en
//   en           in   1      pipeline advance; 0 freezes all state
//   flush        in   1      with en=1, drops outstanding bubbles
//   instr_in     in   WIDTH  instruction from fetch (WIDTH >= 32)
//   instr_out    out  WIDTH  instruction to decode (NOP during bubbles)
//   bubble       out  1      instr_out is an inserted NOP
//   stall_fetch  out  1      fetch must re-present instr_in next cycle
//   slot_cnt     out  4      bubbles remaining, including the current one
//   bubble_total out  16     bubbles issued, saturating at 16'hFFFF

module delay_slot_ctrl #(
    parameter int               WIDTH     = 32,
    parameter int               BR_SLOTS  = 1,
    parameter int               MEM_SLOTS = 1,
    parameter bit               BR_STALL  = 1'b0,
    parameter bit               MEM_STALL = 1'b1,
    parameter logic [WIDTH-1:0] NOP       = 32'h910003FF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             flush,
    input  logic [WIDTH-1:0] instr_in,
    output logic [WIDTH-1:0] instr_out,
    output logic             bubble,
    output logic             stall_fetch,
    output logic [3:0]       slot_cnt,
    output logic [15:0]      bubble_total
);

    localparam logic [3:0] BR_N  = 4'(BR_SLOTS);
    localparam logic [3:0] MEM_N = 4'(MEM_SLOTS);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t      state;
    state_t      state_next;
    logic [3:0]  cnt_next;
    logic        mode;
    logic        mode_next;
    logic [15:0] total_next;
    logic        is_branch;
    logic        is_mem;

    // The two class patterns are disjoint: memory class needs bits 28:26 = 110.
    assign is_branch = (instr_in[28:26] == 3'b101);
    assign is_mem    = (instr_in[31:23] == 9'b111110000) && !instr_in[21];

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            slot_cnt     <= 4'd0;
            mode         <= 1'b0;
            bubble_total <= 16'd0;
        end else begin
            state        <= state_next;
            slot_cnt     <= cnt_next;
            mode         <= mode_next;
            bubble_total <= total_next;
        end
    end

    // Next-state logic. state mirrors (slot_cnt != 0); both are updated here
    // together so they can never disagree.
    always_comb begin
        state_next = state;
        cnt_next   = slot_cnt;
        mode_next  = mode;
        total_next = bubble_total;
        if (en) begin
            if (flush) begin
                // Flush wins over both decrement and a new load; the bubble
                // being shown on a flushed edge is not counted as issued.
                state_next = IDLE;
                cnt_next   = 4'd0;
            end else begin
                case (state)
                    IDLE: begin
                        if (is_branch && (BR_N != 4'd0)) begin
                            state_next = BUSY;
                            cnt_next   = BR_N;
                            mode_next  = BR_STALL;
                        end else if (is_mem && (MEM_N != 4'd0)) begin
                            state_next = BUSY;
                            cnt_next   = MEM_N;
                            mode_next  = MEM_STALL;
                        end
                    end
                    BUSY: begin
                        cnt_next = slot_cnt - 4'd1;
                        if (bubble_total != 16'hFFFF) begin
                            total_next = bubble_total + 16'd1;
                        end
                        if (slot_cnt == 4'd1) begin
                            state_next = IDLE;
                        end
                    end
                    default: begin
                        state_next = IDLE;
                        cnt_next   = 4'd0;
                    end
                endcase
            end
        end
    end

    // Outputs depend only on registered state and instr_in, never on en/flush.
    always_comb begin
        bubble      = 1'b0;
        stall_fetch = 1'b0;
        instr_out   = instr_in;
        if (slot_cnt != 4'd0) begin
            bubble      = 1'b1;
            stall_fetch = mode;
            instr_out   = NOP;
        end
    end

endmodule

// File: tb/tb_delay_slot_ctrl.sv
// tb/tb_delay_slot_ctrl.sv - self-checking bench for delay_slot_ctrl

module tb_delay_slot_ctrl;

    localparam logic [31:0] I_ADD  = 32'h8B020020;
    localparam logic [31:0] I_B    = 32'h14000004;
    localparam logic [31:0] I_LDUR = 32'hF8400020;
    localparam logic [31:0] I_NOP  = 32'h910003FF;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        en = 1'b0;
    logic        flush = 1'b0;
    logic [31:0] instr_in = 32'h0;

    logic [31:0] a_out, b_out, c_out, d_out;
    logic        a_bub, b_bub, c_bub, d_bub;
    logic        a_stl, b_stl, c_stl, d_stl;
    logic [3:0]  a_cnt, b_cnt, c_cnt, d_cnt;
    logic [15:0] a_tot, b_tot, c_tot, d_tot;

    int pass_cnt = 0;
    int total_cnt = 0;

    logic [53:0] sb[$];

    always #5 clk = ~clk;

    // a: defaults; b: MEM_SLOTS=3; c: BR_SLOTS=4; d: BR_SLOTS=15
    delay_slot_ctrl u_a (.clk(clk), .reset(reset), .en(en), .flush(flush), .instr_in(instr_in),
        .instr_out(a_out), .bubble(a_bub), .stall_fetch(a_stl), .slot_cnt(a_cnt), .bubble_total(a_tot));
    delay_slot_ctrl #(.MEM_SLOTS(3)) u_b (.clk(clk), .reset(reset), .en(en), .flush(flush), .instr_in(instr_in),
        .instr_out(b_out), .bubble(b_bub), .stall_fetch(b_stl), .slot_cnt(b_cnt), .bubble_total(b_tot));
    delay_slot_ctrl #(.BR_SLOTS(4)) u_c (.clk(clk), .reset(reset), .en(en), .flush(flush), .instr_in(instr_in),
        .instr_out(c_out), .bubble(c_bub), .stall_fetch(c_stl), .slot_cnt(c_cnt), .bubble_total(c_tot));
    delay_slot_ctrl #(.BR_SLOTS(15)) u_d (.clk(clk), .reset(reset), .en(en), .flush(flush), .instr_in(instr_in),
        .instr_out(d_out), .bubble(d_bub), .stall_fetch(d_stl), .slot_cnt(d_cnt), .bubble_total(d_tot));

    wire [53:0] a_obs = {a_out, a_bub, a_stl, a_cnt, a_tot};
    wire [53:0] b_obs = {b_out, b_bub, b_stl, b_cnt, b_tot};
    wire [53:0] c_obs = {c_out, c_bub, c_stl, c_cnt, c_tot};
    wire [53:0] d_obs = {d_out, d_bub, d_stl, d_cnt, d_tot};

    function automatic logic [34:0] st(input logic r, input logic e, input logic f, input logic [31:0] i);
        return {r, e, f, i};
    endfunction

    function automatic logic [53:0] ex(input logic [31:0] i, input logic b, input logic s,
                                       input logic [3:0] c, input logic [15:0] t);
        return {i, b, s, c, t};
    endfunction

    // Drive one cycle's inputs after the falling edge; outputs settle before the
    // next rising edge and are sampled when this task returns.
    task automatic step(input logic [34:0] s);
        @(negedge clk);
        reset    = s[34];
        en       = s[33];
        flush    = s[32];
        instr_in = s[31:0];
        #2;
    endtask

    task automatic report(input string name, input int idx, input logic [53:0] got, input logic [53:0] want);
        $display("FAIL %s[%0d]: got instr=%h bub=%b stall=%b cnt=%0d tot=%0d, expected instr=%h bub=%b stall=%b cnt=%0d tot=%0d",
                 name, idx, got[53:22], got[21], got[20], got[19:16], got[15:0],
                 want[53:22], want[21], want[20], want[19:16], want[15:0]);
    endtask

    task automatic test_reset();
        logic [34:0] s[$];
        logic [53:0] e[$];
        logic [53:0] want;
        s.push_back(st(1, 1, 0, I_B));   e.push_back(54'h0);
        s.push_back(st(0, 1, 0, I_ADD)); e.push_back(ex(I_ADD, 0, 0, 0, 0));
        for (int i = 0; i < s.size(); i++) begin
            sb.push_back(e[i]);
            step(s[i]);
            want = sb.pop_front();
            if (i == 0) continue;
            total_cnt++;
            if (a_obs !== want) report("reset", i, a_obs, want); else pass_cnt++;
        end
    endtask

    task automatic test_branch_squash();
        logic [34:0] s[$];
        logic [53:0] e[$];
        logic [53:0] want;
        s.push_back(st(1, 1, 0, I_ADD)); e.push_back(54'h0);
        s.push_back(st(0, 1, 0, I_B));   e.push_back(ex(I_B,   0, 0, 0, 0));
        s.push_back(st(0, 1, 0, I_ADD)); e.push_back(ex(I_NOP, 1, 0, 1, 0));
        s.push_back(st(0, 1, 0, I_ADD)); e.push_back(ex(I_ADD, 0, 0, 0, 1));
        for (int i = 0; i < s.size(); i++) begin
            sb.push_back(e[i]);
            step(s[i]);
            want = sb.pop_front();
            if (i == 0) continue;
            total_cnt++;
            if (a_obs !== want) report("branch_squash", i, a_obs, want); else pass_cnt++;
        end
    endtask

    task automatic test_mem_stall();
        logic [34:0] s[$];
        logic [53:0] e[$];
        logic [53:0] want;
        s.push_back(st(1, 1, 0, I_ADD));  e.push_back(54'h0);
        s.push_back(st(0, 1, 0, I_LDUR)); e.push_back(ex(I_LDUR, 0, 0, 0, 0));
        s.push_back(st(0, 1, 0, I_ADD));  e.push_back(ex(I_NOP,  1, 1, 1, 0));
        s.push_back(st(0, 1, 0, I_ADD));  e.push_back(ex(I_ADD,  0, 0, 0, 1));
        for (int i = 0; i < s.size(); i++) begin
            sb.push_back(e[i]);
            step(s[i]);
            want = sb.pop_front();
            if (i == 0) continue;
            total_cnt++;
            if (a_obs !== want) report("mem_stall", i, a_obs, want); else pass_cnt++;
        end
    endtask

    task automatic test_mem3_en_hold();
        logic [34:0] s[$];
        logic [53:0] e[$];
        logic [53:0] want;
        s.push_back(st(1, 1, 0, I_ADD));  e.push_back(54'h0);
        s.push_back(st(0, 1, 0, I_LDUR)); e.push_back(ex(I_LDUR, 0, 0, 0, 0));
        s.push_back(st(0, 1, 0, I_ADD));  e.push_back(ex(I_NOP,  1, 1, 3, 0));
        s.push_back(st(0, 0, 0, I_ADD));  e.push_back(ex(I_NOP,  1, 1, 2, 1));
        s.push_back(st(0, 1, 0, I_ADD));  e.push_back(ex(I_NOP,  1, 1, 2, 1));
        s.push_back(st(0, 1, 0, I_ADD));  e.push_back(ex(I_NOP,  1, 1, 1, 2));
        s.push_back(st(0, 1, 0, I_ADD));  e.push_back(ex(I_ADD,  0, 0, 0, 3));
        for (int i = 0; i < s.size(); i++) begin
            sb.push_back(e[i]);
            step(s[i]);
            want = sb.pop_front();
            if (i == 0) continue;
            total_cnt++;
            if (b_obs !== want) report("mem3_en_hold", i, b_obs, want); else pass_cnt++;
        end
    endtask

    task automatic test_flush();
        logic [34:0] s[$];
        logic [53:0] e[$];
        logic [53:0] want;
        s.push_back(st(1, 1, 0, I_ADD)); e.push_back(54'h0);
        s.push_back(st(0, 1, 0, I_B));   e.push_back(ex(I_B,   0, 0, 0, 0));
        s.push_back(st(0, 1, 0, I_ADD)); e.push_back(ex(I_NOP, 1, 0, 4, 0));
        s.push_back(st(0, 1, 1, I_ADD)); e.push_back(ex(I_NOP, 1, 0, 3, 1));
        s.push_back(st(0, 1, 0, I_B));   e.push_back(ex(I_B,   0, 0, 0, 1));
        s.push_back(st(0, 0, 1, I_ADD)); e.push_back(ex(I_NOP, 1, 0, 4, 1));
        s.push_back(st(0, 1, 0, I_ADD)); e.push_back(ex(I_NOP, 1, 0, 4, 1));
        s.push_back(st(0, 1, 1, I_ADD)); e.push_back(ex(I_NOP, 1, 0, 3, 2));
        s.push_back(st(0, 1, 1, I_B));   e.push_back(ex(I_B,   0, 0, 0, 2));
        s.push_back(st(0, 1, 0, I_ADD)); e.push_back(ex(I_ADD, 0, 0, 0, 2));
        for (int i = 0; i < s.size(); i++) begin
            sb.push_back(e[i]);
            step(s[i]);
            want = sb.pop_front();
            if (i == 0) continue;
            total_cnt++;
            if (c_obs !== want) report("flush", i, c_obs, want); else pass_cnt++;
        end
    endtask

    task automatic test_back_to_back();
        logic [34:0] s[$];
        logic [53:0] e[$];
        logic [53:0] want;
        s.push_back(st(1, 1, 0, I_ADD));  e.push_back(54'h0);
        s.push_back(st(0, 1, 0, I_B));    e.push_back(ex(I_B,    0, 0, 0, 0));
        s.push_back(st(0, 1, 0, I_B));    e.push_back(ex(I_NOP,  1, 0, 1, 0));
        s.push_back(st(0, 1, 0, I_LDUR)); e.push_back(ex(I_LDUR, 0, 0, 0, 1));
        s.push_back(st(0, 1, 0, I_ADD));  e.push_back(ex(I_NOP,  1, 1, 1, 1));
        s.push_back(st(0, 1, 0, I_ADD));  e.push_back(ex(I_ADD,  0, 0, 0, 2));
        for (int i = 0; i < s.size(); i++) begin
            sb.push_back(e[i]);
            step(s[i]);
            want = sb.pop_front();
            if (i == 0) continue;
            total_cnt++;
            if (a_obs !== want) report("back_to_back", i, a_obs, want); else pass_cnt++;
        end
    endtask

    task automatic test_saturation_and_reset();
        logic [15:0] prev;
        logic        wrapped;
        logic [15:0] want_tot;
        logic [53:0] want;
        int          guard;
        step(st(1, 1, 0, I_B));
        prev    = 16'd0;
        wrapped = 1'b0;
        // 16 cycles per 15 bubbles; 70000 cycles issue well over 65535 bubbles.
        for (int i = 0; i < 70000; i++) begin
            step(st(0, 1, 0, I_B));
            if (d_tot < prev) wrapped = 1'b1;
            prev = d_tot;
        end
        sb.push_back({32'h0, 6'h0, 16'hFFFF});
        want_tot = sb.pop_front()[15:0];
        total_cnt++;
        if (d_tot !== want_tot) $display("FAIL saturate: got tot=%h, expected tot=%h", d_tot, want_tot);
        else pass_cnt++;
        total_cnt++;
        if (wrapped !== 1'b0) $display("FAIL no_wrap: got wrapped=%b, expected wrapped=0", wrapped);
        else pass_cnt++;
        guard = 0;
        while (d_bub !== 1'b1 && guard < 20) begin
            step(st(0, 1, 0, I_B));
            guard++;
        end
        total_cnt++;
        if (d_bub !== 1'b1) $display("FAIL busy_before_reset: got bub=%b, expected bub=1", d_bub);
        else pass_cnt++;
        step(st(1, 1, 0, I_ADD));
        sb.push_back(ex(I_ADD, 0, 0, 0, 0));
        step(st(0, 1, 0, I_ADD));
        want = sb.pop_front();
        total_cnt++;
        if (d_obs !== want) report("reset_mid_busy", 0, d_obs, want); else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_branch_squash();
        test_mem_stall();
        test_mem3_en_hold();
        test_flush();
        test_back_to_back();
        test_saturation_and_reset();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
